// File: rtl/jtdsp16_pkg.sv
// Shared encodings for the XAAU program sequencer: register-load selects,
// interrupt vectors and hardware-loop states.
package jtdsp16_pkg;

  typedef enum logic [1:0] {
    LD_PT  = 2'd0,
    LD_TOP = 2'd1,
    LD_PI  = 2'd2,
    LD_I   = 2'd3
  } ld_sel_e;

  localparam int IRQ_VEC_EXT = 0;
  localparam int IRQ_VEC_SW  = 1;

  typedef enum logic {
    LOOP_IDLE = 1'b0,
    LOOP_RUN  = 1'b1
  } loop_st_e;

endpackage

// File: rtl/jtdsp16_xaau_stack_if.sv
// Control/status bundle of the XAAU sequencer; loop signals exist only
// when JTDSP16_XAAU_LOOP_EN is defined.
interface jtdsp16_xaau_stack_if #(
  parameter int AW     = 16,
  parameter int JW     = 12,
  parameter int SDEPTH = 4
);
  localparam int LW = $clog2(SDEPTH) + 1;

  logic          cen;
  logic          goto_ja, call_ja, goto_pt, call_pt;
  logic          ret, iret, icall, ext_irq, pc_halt;
  logic [JW-1:0] j_field;
  logic          ld_en;
  logic [1:0]    ld_sel;
  logic [AW-1:0] ld_data;
  logic          pt_inc;
  logic [AW-1:0] rom_addr;
  logic [AW-1:0] pt_out;
  logic          in_irq;
  logic [LW-1:0] stk_level;
  logic          stk_ovf, stk_unf;
`ifdef JTDSP16_XAAU_LOOP_EN
  logic          do_ld;
  logic [6:0]    do_cnt;
  logic [3:0]    do_len;
  logic          loop_act;
`endif

  modport master (
    output cen, goto_ja, call_ja, goto_pt, call_pt, ret, iret, icall, ext_irq,
           pc_halt, j_field, ld_en, ld_sel, ld_data, pt_inc,
    input  rom_addr, pt_out, in_irq, stk_level, stk_ovf, stk_unf
`ifdef JTDSP16_XAAU_LOOP_EN
    , output do_ld, do_cnt, do_len, input loop_act
`endif
  );

  modport slave (
    input  cen, goto_ja, call_ja, goto_pt, call_pt, ret, iret, icall, ext_irq,
           pc_halt, j_field, ld_en, ld_sel, ld_data, pt_inc,
    output rom_addr, pt_out, in_irq, stk_level, stk_ovf, stk_unf
`ifdef JTDSP16_XAAU_LOOP_EN
    , input do_ld, do_cnt, do_len, output loop_act
`endif
  );

endinterface

// File: rtl/jtdsp16_rstack.sv
// Return-address stack: entry 0 is the top; a push when full drops the oldest
// entry. Overflow/underflow flags are sticky until reset.
module jtdsp16_rstack #(
  parameter int AW     = 16,
  parameter int SDEPTH = 4,
  parameter int LW     = $clog2(SDEPTH) + 1
) (
  input  logic          rst,
  input  logic          clk,
  input  logic          cen,
  input  logic          push,
  input  logic          pop,
  input  logic          wr_top,
  input  logic [AW-1:0] din,
  output logic [AW-1:0] top,
  output logic [LW-1:0] level,
  output logic          ovf,
  output logic          unf
);

  logic [AW-1:0] mem [SDEPTH];
  logic          full, empty;

  assign full  = (level == LW'(SDEPTH));
  assign empty = (level == '0);
  assign top   = mem[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < SDEPTH; k++) mem[k] <= '0;
      level <= '0;
      ovf   <= 1'b0;
      unf   <= 1'b0;
    end else if (cen) begin
      // Writing the top of an empty stack creates the entry.
      if (push || (wr_top && empty)) begin
        mem[0] <= din;
        for (int k = 1; k < SDEPTH; k++) mem[k] <= mem[k-1];
        if (full) ovf   <= 1'b1;
        else      level <= level + LW'(1);
      end else if (pop) begin
        if (empty) begin
          unf <= 1'b1;
        end else begin
          for (int k = 0; k < SDEPTH - 1; k++) mem[k] <= mem[k+1];
          mem[SDEPTH-1] <= '0;
          level         <= level - LW'(1);
        end
      end else if (wr_top) begin
        mem[0] <= din;
      end
    end
  end

endmodule

// File: rtl/jtdsp16_xaau_stack.sv
// XAAU program counter, pt/pi/i registers, interrupts and return stack.
// Optional hardware loop compiled in with JTDSP16_XAAU_LOOP_EN.
module jtdsp16_xaau_stack
  import jtdsp16_pkg::*;
#(
  parameter int AW     = 16,
  parameter int JW     = 12,
  parameter int SDEPTH = 4
) (
  input  logic rst,
  input  logic clk,
  jtdsp16_xaau_stack_if.slave bus
);

  localparam int LW = $clog2(SDEPTH) + 1;

  logic [AW-1:0] pc, pc_nxt, pc_inc, pt, pi, stk_top;
  logic [JW-1:0] i_reg;
  logic          in_irq;
  logic          irq_take, any_ja, any_pt, seq;
  logic          push, pop, wr_top;
  logic [LW-1:0] level;
  logic          loop_jmp;
  logic [AW-1:0] loop_pc;

  assign pc_inc   = pc + AW'(1);
  assign irq_take = !in_irq && (bus.ext_irq || bus.icall);
  assign any_ja   = bus.goto_ja || bus.call_ja;
  assign any_pt   = bus.goto_pt || bus.call_pt;
  assign seq      = !(irq_take || any_ja || any_pt || bus.ret || bus.iret || bus.pc_halt);

  // A call pushes only when it is the branch that actually wins.
  assign push   = bus.cen && !irq_take && (any_ja ? bus.call_ja : bus.call_pt);
  assign pop    = bus.cen && !irq_take && !any_ja && !any_pt && bus.ret;
  assign wr_top = bus.cen && bus.ld_en && (bus.ld_sel == LD_TOP) && !push;

  always_comb begin
    pc_nxt = pc_inc;
    if (irq_take)
      pc_nxt = bus.ext_irq ? AW'(IRQ_VEC_EXT) : AW'(IRQ_VEC_SW);
    else if (any_ja)
      pc_nxt = {pc[AW-1:JW], bus.j_field};
    else if (any_pt)
      pc_nxt = pt;
    else if (bus.ret)
      pc_nxt = (level == '0) ? pc_inc : stk_top;
    else if (bus.iret)
      pc_nxt = pi;
    else if (bus.pc_halt)
      pc_nxt = pc;
    else if (loop_jmp)
      pc_nxt = loop_pc;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc     <= '0;
      pt     <= '0;
      pi     <= '0;
      i_reg  <= '0;
      in_irq <= 1'b0;
    end else if (bus.cen) begin
      pc <= pc_nxt;
      if (bus.ld_en && bus.ld_sel == LD_PT)
        pt <= bus.ld_data;
      else if (bus.pt_inc)
        pt <= pt + {{(AW-JW){i_reg[JW-1]}}, i_reg};
      if (bus.ld_en && bus.ld_sel == LD_PI)
        pi <= bus.ld_data;
      else if (irq_take)
        pi <= pc;
      if (bus.ld_en && bus.ld_sel == LD_I)
        i_reg <= bus.ld_data[JW-1:0];
      if (irq_take)
        in_irq <= 1'b1;
      else if (bus.iret)
        in_irq <= 1'b0;
    end
  end

`ifdef JTDSP16_XAAU_LOOP_EN
  loop_st_e      lp_st, lp_st_nxt;
  logic [AW-1:0] lp_start, lp_start_nxt, lp_end, lp_end_nxt;
  logic [6:0]    lp_cnt, lp_cnt_nxt;

  always_comb begin
    lp_st_nxt    = lp_st;
    lp_start_nxt = lp_start;
    lp_end_nxt   = lp_end;
    lp_cnt_nxt   = lp_cnt;
    loop_jmp     = 1'b0;
    // Only sequential flow closes the loop; branches and interrupts leave it alone.
    if (lp_st == LOOP_RUN && seq && pc == lp_end) begin
      if (lp_cnt > 7'd1) begin
        loop_jmp   = 1'b1;
        lp_cnt_nxt = lp_cnt - 7'd1;
      end else begin
        lp_st_nxt  = LOOP_IDLE;
      end
    end
    if (bus.do_ld && bus.do_cnt != '0 && bus.do_len != '0) begin
      lp_st_nxt    = LOOP_RUN;
      lp_start_nxt = pc_inc;
      lp_end_nxt   = pc + AW'(bus.do_len);
      lp_cnt_nxt   = bus.do_cnt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lp_st    <= LOOP_IDLE;
      lp_start <= '0;
      lp_end   <= '0;
      lp_cnt   <= '0;
    end else if (bus.cen) begin
      lp_st    <= lp_st_nxt;
      lp_start <= lp_start_nxt;
      lp_end   <= lp_end_nxt;
      lp_cnt   <= lp_cnt_nxt;
    end
  end

  assign loop_pc      = lp_start;
  assign bus.loop_act = (lp_st == LOOP_RUN);
`else
  assign loop_jmp = 1'b0;
  assign loop_pc  = '0;
`endif

  jtdsp16_rstack #(.AW(AW), .SDEPTH(SDEPTH), .LW(LW)) u_rstack (
    .rst    (rst),
    .clk    (clk),
    .cen    (bus.cen),
    .push   (push),
    .pop    (pop),
    .wr_top (wr_top),
    .din    (push ? pc_inc : bus.ld_data),
    .top    (stk_top),
    .level  (level),
    .ovf    (bus.stk_ovf),
    .unf    (bus.stk_unf)
  );

  assign bus.rom_addr  = pc;
  assign bus.pt_out    = pt;
  assign bus.in_irq    = in_irq;
  assign bus.stk_level = level;

endmodule

// File: tb/tb_jtdsp16_xaau_stack.sv
// Directed vector bench for jtdsp16_xaau_stack: table of single-cycle
// stimuli with expected state, plus reset-abort and hardware-loop sequences.
module tb_jtdsp16_xaau_stack;

  localparam int F_GJA   = 1;
  localparam int F_CJA   = 2;
  localparam int F_GPT   = 4;
  localparam int F_CPT   = 8;
  localparam int F_RET   = 16;
  localparam int F_IRET  = 32;
  localparam int F_ICALL = 64;
  localparam int F_EIRQ  = 128;
  localparam int F_HALT  = 256;
  localparam int F_LD    = 512;
  localparam int F_INC   = 1024;
  localparam int F_NOCEN = 2048;

  typedef struct {
    int            flags;
    logic [11:0]   jf;
    logic [1:0]    sel;
    logic [15:0]   d;
    logic [15:0]   e_pc;
    logic [15:0]   e_pt;
    logic          e_irq;
    logic [2:0]    e_lvl;
    logic          e_ovf;
    logic          e_unf;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  vec_t vecs[$];

  jtdsp16_xaau_stack_if #(.AW(16), .JW(12), .SDEPTH(4)) sif ();

  jtdsp16_xaau_stack #(.AW(16), .JW(12), .SDEPTH(4)) dut (
    .rst (rst),
    .clk (clk),
    .bus (sif)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(int f, int jf, int sel, int d, int epc, int ept,
                              int eirq, int elvl, int eovf, int eunf);
    vec_t r;
    r.flags = f;
    r.jf    = 12'(jf);
    r.sel   = 2'(sel);
    r.d     = 16'(d);
    r.e_pc  = 16'(epc);
    r.e_pt  = 16'(ept);
    r.e_irq = 1'(eirq);
    r.e_lvl = 3'(elvl);
    r.e_ovf = 1'(eovf);
    r.e_unf = 1'(eunf);
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic clear_in();
    sif.cen = 1'b1;  sif.goto_ja = 1'b0; sif.call_ja = 1'b0;
    sif.goto_pt = 1'b0; sif.call_pt = 1'b0; sif.ret = 1'b0; sif.iret = 1'b0;
    sif.icall = 1'b0; sif.ext_irq = 1'b0; sif.pc_halt = 1'b0;
    sif.j_field = '0; sif.ld_en = 1'b0; sif.ld_sel = '0; sif.ld_data = '0;
    sif.pt_inc = 1'b0;
`ifdef JTDSP16_XAAU_LOOP_EN
    sif.do_ld = 1'b0; sif.do_cnt = '0; sif.do_len = '0;
`endif
  endtask

  task automatic apply(input vec_t v);
    sif.cen     = (v.flags & F_NOCEN) == 0;
    sif.goto_ja = (v.flags & F_GJA)   != 0;
    sif.call_ja = (v.flags & F_CJA)   != 0;
    sif.goto_pt = (v.flags & F_GPT)   != 0;
    sif.call_pt = (v.flags & F_CPT)   != 0;
    sif.ret     = (v.flags & F_RET)   != 0;
    sif.iret    = (v.flags & F_IRET)  != 0;
    sif.icall   = (v.flags & F_ICALL) != 0;
    sif.ext_irq = (v.flags & F_EIRQ)  != 0;
    sif.pc_halt = (v.flags & F_HALT)  != 0;
    sif.ld_en   = (v.flags & F_LD)    != 0;
    sif.pt_inc  = (v.flags & F_INC)   != 0;
    sif.j_field = v.jf;
    sif.ld_sel  = v.sel;
    sif.ld_data = v.d;
    @(posedge clk);
    #1;
    clear_in();
  endtask

  task automatic chk_state(input string tag, input logic [15:0] pc, input logic [15:0] pt,
                           input logic irq, input logic [2:0] lvl, input logic ovf, input logic unf);
    chk({tag, ".pc"},  32'(sif.rom_addr),  32'(pc));
    chk({tag, ".pt"},  32'(sif.pt_out),    32'(pt));
    chk({tag, ".irq"}, 32'(sif.in_irq),    32'(irq));
    chk({tag, ".lvl"}, 32'(sif.stk_level), 32'(lvl));
    chk({tag, ".ovf"}, 32'(sif.stk_ovf),   32'(ovf));
    chk({tag, ".unf"}, 32'(sif.stk_unf),   32'(unf));
  endtask

  initial begin
    clear_in();
    //            flags            jf     sel d        pc       pt      irq lvl ovf unf
    vecs.push_back(mk(F_LD,          0,     0, 'h4010, 'h0001, 'h4010, 0, 0, 0, 0));
    vecs.push_back(mk(F_GPT,         0,     0, 0,      'h4010, 'h4010, 0, 0, 0, 0));
    vecs.push_back(mk(F_CJA,         'h123, 0, 0,      'h4123, 'h4010, 0, 1, 0, 0));
    vecs.push_back(mk(F_RET,         0,     0, 0,      'h4011, 'h4010, 0, 0, 0, 0));
    vecs.push_back(mk(F_LD,          0,     0, 'h1000, 'h4012, 'h1000, 0, 0, 0, 0));
    vecs.push_back(mk(F_LD,          0,     3, 'h0FFE, 'h4013, 'h1000, 0, 0, 0, 0));
    vecs.push_back(mk(F_INC,         0,     0, 0,      'h4014, 'h0FFE, 0, 0, 0, 0));
    vecs.push_back(mk(F_INC,         0,     0, 0,      'h4015, 'h0FFC, 0, 0, 0, 0));
    vecs.push_back(mk(F_INC,         0,     0, 0,      'h4016, 'h0FFA, 0, 0, 0, 0));
    vecs.push_back(mk(F_GPT,         0,     0, 0,      'h0FFA, 'h0FFA, 0, 0, 0, 0));
    vecs.push_back(mk(F_HALT,        0,     0, 0,      'h0FFA, 'h0FFA, 0, 0, 0, 0));
    vecs.push_back(mk(F_NOCEN|F_GJA, 'h555, 0, 0,      'h0FFA, 'h0FFA, 0, 0, 0, 0));
    vecs.push_back(mk(F_LD,          0,     0, 'h0200, 'h0FFB, 'h0200, 0, 0, 0, 0));
    vecs.push_back(mk(F_GPT,         0,     0, 0,      'h0200, 'h0200, 0, 0, 0, 0));
    vecs.push_back(mk(F_EIRQ,        0,     0, 0,      'h0000, 'h0200, 1, 0, 0, 0));
    vecs.push_back(mk(F_EIRQ,        0,     0, 0,      'h0001, 'h0200, 1, 0, 0, 0));
    vecs.push_back(mk(F_ICALL,       0,     0, 0,      'h0002, 'h0200, 1, 0, 0, 0));
    vecs.push_back(mk(F_IRET,        0,     0, 0,      'h0200, 'h0200, 0, 0, 0, 0));
    vecs.push_back(mk(F_ICALL,       0,     0, 0,      'h0001, 'h0200, 1, 0, 0, 0));
    vecs.push_back(mk(F_IRET,        0,     0, 0,      'h0200, 'h0200, 0, 0, 0, 0));
    vecs.push_back(mk(F_IRET,        0,     0, 0,      'h0200, 'h0200, 0, 0, 0, 0));
    vecs.push_back(mk(F_CJA,         'h100, 0, 0,      'h0100, 'h0200, 0, 1, 0, 0));
    vecs.push_back(mk(F_CJA,         'h110, 0, 0,      'h0110, 'h0200, 0, 2, 0, 0));
    vecs.push_back(mk(F_CJA,         'h120, 0, 0,      'h0120, 'h0200, 0, 3, 0, 0));
    vecs.push_back(mk(F_CJA,         'h130, 0, 0,      'h0130, 'h0200, 0, 4, 0, 0));
    vecs.push_back(mk(F_CJA,         'h140, 0, 0,      'h0140, 'h0200, 0, 4, 1, 0));
    vecs.push_back(mk(F_RET,         0,     0, 0,      'h0131, 'h0200, 0, 3, 1, 0));
    vecs.push_back(mk(F_RET,         0,     0, 0,      'h0121, 'h0200, 0, 2, 1, 0));
    vecs.push_back(mk(F_RET,         0,     0, 0,      'h0111, 'h0200, 0, 1, 1, 0));
    vecs.push_back(mk(F_RET,         0,     0, 0,      'h0101, 'h0200, 0, 0, 1, 0));
    vecs.push_back(mk(F_RET,         0,     0, 0,      'h0102, 'h0200, 0, 0, 1, 1));
    vecs.push_back(mk(F_LD,          0,     1, 'h0ABC, 'h0103, 'h0200, 0, 1, 1, 1));
    vecs.push_back(mk(F_RET,         0,     0, 0,      'h0ABC, 'h0200, 0, 0, 1, 1));
    vecs.push_back(mk(F_CJA|F_LD,    'h050, 1, 'h0777, 'h0050, 'h0200, 0, 1, 1, 1));
    vecs.push_back(mk(F_RET,         0,     0, 0,      'h0ABD, 'h0200, 0, 0, 1, 1));
    vecs.push_back(mk(F_LD|F_EIRQ,   0,     2, 'h0333, 'h0000, 'h0200, 1, 0, 1, 1));
    vecs.push_back(mk(F_IRET,        0,     0, 0,      'h0333, 'h0200, 0, 0, 1, 1));
    vecs.push_back(mk(F_LD|F_INC,    0,     0, 'h2000, 'h0334, 'h2000, 0, 0, 1, 1));
    vecs.push_back(mk(F_EIRQ|F_GJA|F_CPT, 'h777, 0, 0, 'h0000, 'h2000, 1, 0, 1, 1));
    vecs.push_back(mk(F_IRET,        0,     0, 0,      'h0334, 'h2000, 0, 0, 1, 1));
    vecs.push_back(mk(F_LD,          0,     0, 'hFFFF, 'h0335, 'hFFFF, 0, 0, 1, 1));
    vecs.push_back(mk(F_GPT,         0,     0, 0,      'hFFFF, 'hFFFF, 0, 0, 1, 1));
    vecs.push_back(mk(0,             0,     0, 0,      'h0000, 'hFFFF, 0, 0, 1, 1));
    vecs.push_back(mk(F_CPT,         0,     0, 0,      'hFFFF, 'hFFFF, 0, 1, 1, 1));
    vecs.push_back(mk(F_GJA,         'h234, 0, 0,      'hF234, 'hFFFF, 0, 1, 1, 1));
    vecs.push_back(mk(F_RET,         0,     0, 0,      'h0001, 'hFFFF, 0, 0, 1, 1));

    repeat (2) @(posedge clk);
    #1;
    chk_state("reset", 16'h0000, 16'h0000, 1'b0, 3'd0, 1'b0, 1'b0);
    rst = 1'b0;

    for (int n = 0; n < vecs.size(); n++)
      begin
        apply(vecs[n]);
        chk_state($sformatf("vec%0d", n), vecs[n].e_pc, vecs[n].e_pt, vecs[n].e_irq,
                  vecs[n].e_lvl, vecs[n].e_ovf, vecs[n].e_unf);
      end

    // Reset in the middle of a cycle must clear state at once and abort the branch.
    apply(mk(F_EIRQ, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    apply(mk(F_CJA, 'h321, 0, 0, 0, 0, 0, 0, 0, 0));
    chk_state("pre_rst", 16'h0321, 16'hFFFF, 1'b1, 3'd1, 1'b1, 1'b1);
    sif.goto_pt = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk_state("async_rst", 16'h0000, 16'h0000, 1'b0, 3'd0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    chk("rst_hold.pc", 32'(sif.rom_addr), 32'h0);
    clear_in();
    rst = 1'b0;
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    chk("post_rst.pc", 32'(sif.rom_addr), 32'h1);

`ifdef JTDSP16_XAAU_LOOP_EN
    begin
      logic [15:0] exp_pc [7];
      logic        exp_act [7];
      exp_pc  = '{16'h11, 16'h12, 16'h11, 16'h12, 16'h11, 16'h12, 16'h13};
      exp_act = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      chk("loop.idle", 32'(sif.loop_act), 32'h0);
      apply(mk(F_LD, 0, 0, 'h0010, 0, 0, 0, 0, 0, 0));
      apply(mk(F_GPT, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      chk("loop.start_pc", 32'(sif.rom_addr), 32'h10);
      sif.do_ld = 1'b1; sif.do_cnt = 7'd3; sif.do_len = 4'd2;
      @(posedge clk);
      #1;
      clear_in();
      for (int s = 0; s < 7; s++) begin
        chk($sformatf("loop.pc%0d", s),  32'(sif.rom_addr), 32'(exp_pc[s]));
        chk($sformatf("loop.act%0d", s), 32'(sif.loop_act), 32'(exp_act[s]));
        @(posedge clk);
        #1;
      end
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/jtdsp16_xaau_stack.md
JTDSP16_XAAU_STACK -- requirements
Module: jtdsp16_xaau_stack

Interface
REQ-001 SHALL have parameter AW, default 16, ROM address width.
REQ-002 SHALL have parameter JW, default 12, jump-field width (JW < AW).
REQ-003 SHALL have parameter SDEPTH, default 4, return-stack depth (power of two, >=2).
REQ-004 Ports SHALL be:
 - rst  in  1  reset, asynchronous, active-high
 - clk  in  1  clock
 - cen  in  1  clock enable; all state advances only when high
 - goto_ja / call_ja  in  1  direct jump / call to {pc[AW-1:JW], j_field}
 - goto_pt / call_pt  in  1  jump / call to pt
 - ret / iret  in  1  return from call / interrupt
 - icall  in  1  software interrupt, vector 1
 - ext_irq  in  1  external interrupt, vector 0
 - pc_halt  in  1  hold pc
 - j_field  in  JW  jump target field
 - ld_en  in  1  register load strobe
 - ld_sel  in  2  0=pt, 1=stack top, 2=pi, 3=i
 - ld_data  in  AW  load value
 - pt_inc  in  1  pt <= pt + sign-extended i
 - rom_addr  out  AW  current pc
 - pt_out  out  AW  table pointer
 - in_irq  out  1  interrupt service active
 - stk_level  out  clog2(SDEPTH)+1  stack occupancy
 - stk_ovf / stk_unf  out  1  sticky overflow / underflow

Function
REQ-005 rom_addr SHALL equal pc directly (no output register beyond pc).
REQ-006 pc update priority SHALL be: accepted ext_irq -> 0; accepted icall -> 1; goto_ja/call_ja -> {pc[AW-1:JW], j_field}; goto_pt/call_pt -> pt; ret -> stack top; iret -> pi; pc_halt -> pc; else pc+1 (modulo 2^AW).
REQ-007 ext_irq and icall SHALL be accepted only when in_irq=0; accepted interrupt sets in_irq, stores pi <= pc (resume address), and overrides any simultaneous branch.
REQ-008 iret SHALL clear in_irq; iret with in_irq=0 SHALL still load pc <= pi.
REQ-009 call_ja/call_pt SHALL push pc+1 onto the stack in the same cen cycle as the jump.
REQ-010 ret SHALL pop; stack top becomes next-older entry.
REQ-011 Push when stk_level==SDEPTH SHALL discard the oldest entry, keep level at SDEPTH, set stk_ovf.
REQ-012 ret when stk_level==0 SHALL load pc <= pc+1, leave level 0, set stk_unf.
REQ-013 ld_en with ld_sel=1 SHALL overwrite stack top (push if level==0); with call in same cycle, call push wins and load is dropped.
REQ-014 ld_en with ld_sel=0/2/3 SHALL write pt/pi/i; ld_en pt has priority over pt_inc; pi load has priority over interrupt capture.
REQ-015 i SHALL be JW bits (ld_data[JW-1:0]); pt_inc adds {sign-extended i} modulo 2^AW.
REQ-016 stk_ovf/stk_unf SHALL stay set until reset.

Reset
REQ-017 On rst: pc=0, pt=0, pi=0, i=0, stack entries=0, stk_level=0, in_irq=0, stk_ovf=0, stk_unf=0, loop state idle.
REQ-018 rst mid-operation SHALL abort any pending branch, interrupt or loop immediately.

Configuration
REQ-019 Macro JTDSP16_XAAU_LOOP_EN SHALL compile in a hardware loop: extra inputs do_ld (1), do_cnt (7), do_len (4), output loop_act (1).
REQ-020 With it: do_ld captures start=pc+1, end=pc+do_len, count=do_cnt; when pc==end, count>1 and no higher-priority pc source, pc <= start and count decrements; count<=1 at end ends loop (loop_act=0); do_cnt=0 or do_len=0 ignored; interrupts may enter/leave loops without altering loop state.
REQ-021 Without it: ports absent, no loop logic, pc rules of REQ-006 only.

Structure
REQ-022 Package jtdsp16_pkg SHALL hold the ld_sel encodings and interrupt vector constants.
REQ-023 Return stack SHALL be sub-module jtdsp16_rstack (push, pop, write-top, level, ovf, unf).

Verification
REQ-024 call_ja j_field=0x123 at pc=0x4010 -> pc=0x4123, level=1; ret -> pc=0x4011, level=0.
REQ-025 Five nested calls, SDEPTH=4 -> stk_ovf=1, level=4; five rets -> 4 correct returns, fifth gives pc+1, stk_unf=1.
REQ-026 ext_irq at pc=0x0200 -> pc=0, in_irq=1, pi=0x0200; second ext_irq ignored; iret -> pc=0x0200, in_irq=0.
REQ-027 ld_sel=0 data 0x1000, ld_sel=3 data 0xFFE (-2), pt_inc x3 -> pt_out=0x0FFA; goto_pt -> pc=0x0FFA.
REQ-028 LOOP_EN: do_ld cnt=3 len=2 at pc=0x10 -> pc sequence 11,12,11,12,11,12,13; loop_act low after last 12.
